alu_op_sequencer: RTL



---
 rtl/alu_op_sequencer_pkg.sv | 30 +++
 rtl/alu_op_sequencer_lat_decode.sv | 23 ++
 rtl/alu_op_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared ALU definitions: opcode encodings, sequencer states and
// the illegal-opcode rule used by both the ALU and the sequencer.
package alu_op_sequencer_pkg;

  localparam int OP_W  = 5;
  localparam int LAT_W = 8;   // wide enough for any DIV_LAT up to 255

  localparam logic [OP_W-1:0] OP_AND = 5'h00;
  localparam logic [OP_W-1:0] OP_OR  = 5'h01;
  localparam logic [OP_W-1:0] OP_XOR = 5'h02;
  localparam logic [OP_W-1:0] OP_ILL0 = 5'h0C;
  localparam logic [OP_W-1:0] OP_ILL1 = 5'h0D;
  localparam logic [OP_W-1:0] OP_ADD = 5'h11;
  localparam logic [OP_W-1:0] OP_SUB = 5'h12;
  localparam logic [OP_W-1:0] OP_MUL = 5'h13;
  localparam logic [OP_W-1:0] OP_DIV = 5'h14;
  localparam logic [OP_W-1:0] OP_FIRST_ILL_HI = 5'h15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Holes in the opcode map (0x0C, 0x0D) and everything above DIV.
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return (op == OP_ILL0) || (op == OP_ILL1) || (op >= OP_FIRST_ILL_HI);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_lat_decode.sv
// Opcode -> {legal, is_div, latency}; keeps opcode lists out of the FSM.
module alu_lat_decode
  import alu_op_sequencer_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 34
) (
  input  logic [OP_W-1:0]  opcode,
  output logic             legal,
  output logic             is_div,
  output logic [LAT_W-1:0] latency
);

  // Pure decode; illegal opcodes still report latency 1 but are never executed.
  always_comb begin
    legal   = !is_illegal_op(opcode);
    is_div  = (opcode == OP_DIV);
    latency = LAT_W'(1);
    if (opcode == OP_MUL) latency = LAT_W'(MUL_LAT);
    if (opcode == OP_DIV) latency = LAT_W'(DIV_LAT);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: registers the request, waits the
// opcode latency, captures the 64-bit result and holds it until taken.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is high only in IDLE; rsp_valid is high only in RESP and
// the response registers stay stable until rsp_ready is seen.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 34,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_opcode,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [OP_W-1:0]  alu_opcode,
  output logic             div_start,
  input  logic [63:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_hi,
  output logic [31:0]      rsp_lo,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNT_W-1:0] ops_done,
  output state_t           dbg_state
);

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q;
  logic              first_q;     // first EXEC cycle after accept
  logic              is_div_q;
  logic [31:0]       alu_a_q, alu_b_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [31:0]       rsp_hi_q, rsp_lo_q;
  logic              rsp_zero_q, rsp_err_q;
  logic [CNT_W-1:0]  ops_q;

  logic              dec_legal, dec_is_div;
  logic [LAT_W-1:0]  dec_lat;

  alu_lat_decode #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_dec (
    .opcode  (req_opcode),
    .legal   (dec_legal),
    .is_div  (dec_is_div),
    .latency (dec_lat)
  );

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; illegal opcodes skip EXEC and go straight to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = dec_legal ? ST_EXEC : ST_RESP;
      ST_EXEC: if (cnt_q == LAT_W'(1)) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, latency countdown, result capture, op counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q      <= '0;
      first_q    <= 1'b0;
      is_div_q   <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_hi_q   <= '0;
      rsp_lo_q   <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      ops_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            alu_a_q  <= req_a;
            alu_b_q  <= req_b;
            alu_op_q <= req_opcode;
            cnt_q    <= dec_lat;
            is_div_q <= dec_is_div;
            first_q  <= dec_legal;
            if (!dec_legal) begin
              rsp_hi_q   <= '0;
              rsp_lo_q   <= '0;
              rsp_zero_q <= 1'b0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          first_q <= 1'b0;
          cnt_q   <= cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) begin
            rsp_hi_q   <= alu_result[63:32];
            rsp_lo_q   <= alu_result[31:0];
            rsp_zero_q <= (alu_result == 64'd0);
            rsp_err_q  <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) ops_q <= ops_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign div_start  = (state_q == ST_EXEC) && first_q && is_div_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_lo     = rsp_lo_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign ops_done   = ops_q;
  assign dbg_state  = state_q;

endmodule
